// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : clkdiv_pkg
// Purpose  : Shared encodings and default half-period constants for the
//            programmable slow-clock divider.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package clkdiv_pkg;

  // Operating mode encodings; 2'b11 is reserved and treated as pause
  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_PAUSE = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;

  // Period preset encodings
  localparam logic [1:0] RATE_1S  = 2'd0;
  localparam logic [1:0] RATE_2S  = 2'd1;
  localparam logic [1:0] RATE_5S  = 2'd2;
  localparam logic [1:0] RATE_10S = 2'd3;

  // Default half-periods in 50 MHz cycles (1 s / 2 s / 5 s / 10 s periods)
  localparam int DEF_HALF_0 = 25000000;
  localparam int DEF_HALF_1 = 50000000;
  localparam int DEF_HALF_2 = 125000000;
  localparam int DEF_HALF_3 = 250000000;

endpackage
`default_nettype wire

// File: rtl/sync_fall_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sync_fall_detect
// Purpose  : Two-flop synchroniser plus history flop for an asynchronous
//            active-low key; emits a one-cycle pulse on each falling edge.
//            All flops reset to 1 so a key held at reset is not a press.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sync_fall_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronise the key and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A press is the synchronised level newly low; holding low yields one pulse
  assign fall = ~s2 & s3;

endmodule
`default_nettype wire

// File: rtl/clock_divider_prog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : clock_divider_prog
// Purpose  : Programmable slow clock with run / pause / single-step modes.
//            Produces a square wave plus toggle and rising-edge strobes.
//            Rate changes are taken only at a toggle boundary so clk_out
//            never glitches.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module clock_divider_prog #(
  parameter int CNT_W  = 28,
  parameter int HALF_0 = clkdiv_pkg::DEF_HALF_0,
  parameter int HALF_1 = clkdiv_pkg::DEF_HALF_1,
  parameter int HALF_2 = clkdiv_pkg::DEF_HALF_2,
  parameter int HALF_3 = clkdiv_pkg::DEF_HALF_3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] rate_sel,
  input  logic [1:0] mode,
  input  logic       step_n,
  output logic       clk_out,
  output logic       half_tick,
  output logic       tick,
  output logic [1:0] active_rate
);

  import clkdiv_pkg::*;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] term;
  logic             press;

  // Step key conditioning; runs in every mode, consumed only in STEP
  sync_fall_detect u_step_key (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .din   (step_n),
    .fall  (press)
  );

  // Terminal count for the preset currently in force
  always_comb begin
    term = '0;
    case (active_rate)
      RATE_1S:  term = CNT_W'(HALF_0 - 1);
      RATE_2S:  term = CNT_W'(HALF_1 - 1);
      RATE_5S:  term = CNT_W'(HALF_2 - 1);
      RATE_10S: term = CNT_W'(HALF_3 - 1);
      default:  term = CNT_W'(HALF_0 - 1);
    endcase
  end

  // Counter, output toggle, strobes and rate latch
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      clk_out     <= 1'b0;
      half_tick   <= 1'b0;
      tick        <= 1'b0;
      active_rate <= RATE_1S;
    end else begin
      half_tick <= 1'b0;
      tick      <= 1'b0;
      case (mode)
        MODE_RUN: begin
          if (count == term) begin
            count       <= '0;
            clk_out     <= ~clk_out;
            half_tick   <= 1'b1;
            tick        <= ~clk_out;
            active_rate <= rate_sel;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        MODE_STEP: begin
          // Held at zero so a return to RUN starts a full half-period
          count <= '0;
          if (press) begin
            clk_out     <= ~clk_out;
            half_tick   <= 1'b1;
            tick        <= ~clk_out;
            active_rate <= rate_sel;
          end
        end
        default: begin
          // PAUSE and the reserved code freeze everything in place
          count <= count;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Parametrised successor to the fixed 1 Hz divider.
- Derives a slow square-wave clock, plus single-cycle tick strobes, from the 50 MHz board clock.
- The period is selectable from four presets (1/2/5/10 s).
- Run, pause and manual single-step modes, where each step is a debounced-board-key press, let the pipelined processor be clocked slowly or instruction-by-instruction on the board.

Parameters:
- CNT_W, 28: counter width; must hold HALF_3-1.
- HALF_0, 25000000: half-period in CLOCK_50 cycles for rate 0 (1 s period).
- HALF_1, 50000000: half-period for rate 1 (2 s).
- HALF_2, 125000000: half-period for rate 2 (5 s).
- HALF_3, 250000000: half-period for rate 3 (10 s).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- rate_sel  in  2  requested period preset, 0..3.
- mode  in  2  00 RUN, 01 PAUSE, 10 STEP, 11 reserved (behaves as PAUSE).
- step_n  in  1  asynchronous active-low step key; a press is a falling edge.
- clk_out  out  1  divided square wave.
- half_tick  out  1  one-cycle strobe on every clk_out toggle.
- tick  out  1  one-cycle strobe on every clk_out rising transition.
- active_rate  out  2  preset currently in force.

Behaviour:
- Reset (reset=0, async): count=0, clk_out=0, half_tick=0, tick=0, active_rate=0, step synchroniser flops=1.
- Everything is clocked on posedge CLOCK_50. All outputs are registered.
- Terminal value: TERM = HALF_<active_rate> - 1.
- RUN:
  - If count==TERM: count<=0, clk_out<=~clk_out, half_tick<=1, tick<=~clk_out (i.e. 1 only when the new clk_out is 1), active_rate<=rate_sel.
  - Else: count<=count+1, strobes<=0.
  - The period is exactly 2*HALF cycles. Strobes go high in the same cycle that clk_out shows its new value.
- Rate change is only taken at a toggle boundary. rate_sel is sampled at the terminal cycle and governs the next half-period. This keeps clk_out glitch-free; the current half-period always completes at its old length.
- PAUSE (or 11): count, clk_out and active_rate hold; strobes 0. A return to RUN resumes from the frozen count.
- STEP:
  - count is forced to 0 every cycle.
  - Each detected press toggles clk_out once, with half_tick=1 and tick set per the RUN rule.
  - active_rate<=rate_sel on each press.
  - Leaving STEP for RUN starts a full half-period from count 0.
- Step detection:
  - step_n passes through 2 synchroniser flops (s1, s2), then a history flop s3.
  - press = s2==0 and s3==1.
  - Latency: step_n low before edge k gives the clk_out toggle at edge k+2.
  - Press detection runs in all modes but acts only in STEP. A press in RUN/PAUSE is discarded, not queued.
  - Holding step_n low gives exactly one press.
- Mode is sampled each cycle with no extra latency. A mode change and a terminal count in the same cycle: the new mode wins; e.g. RUN->PAUSE at count==TERM freezes at TERM, and the toggle occurs on the first RUN cycle after resume.
- Counter is CNT_W bits unsigned and never exceeds TERM. If rate_sel changes while count>TERM is impossible by construction, nothing needs handling. A parameter HALF_n < 1 is illegal and is not checked in RTL.
- Reset mid-operation: immediate return to reset values; no partial strobe.

Decomposition:
- Shared package clkdiv_pkg holds:
  - mode encodings MODE_RUN=2'b00, MODE_PAUSE=2'b01, MODE_STEP=2'b10;
  - rate encodings RATE_1S..RATE_10S;
  - default half-period constants.
- One sub-module, sync_fall_detect. It contains the 2-flop synchroniser, history flop and falling-edge pulse, with reset value 1. It is reusable for other board keys.

Test Plan (sim with HALF_0=4, HALF_1=8, HALF_2=20, HALF_3=40, CNT_W=8):
- Reset release, mode=RUN, rate_sel=0 -> clk_out toggles every 4 cycles (period 8); half_tick every 4th cycle; tick only at 0->1; first toggle 4 cycles after reset deassertion.
- rate_sel 0->1 in the middle of a half-period -> current half-period finishes at 4 cycles, then toggles every 8; active_rate becomes 1 at that boundary.
- RUN at count=2, mode->PAUSE for 10 cycles, then RUN -> clk_out constant, no strobes during pause; the toggle comes 2 cycles after resume.
- mode=STEP, step_n low for 50 cycles, then high, then low again -> exactly two toggles, each 2 edges after the fall; no toggles from the counter.
- Assert reset while clk_out=1 and count=3 -> clk_out=0, count=0, strobes 0 immediately; clean restart after release.
- mode=11 -> identical to PAUSE; press step_n in RUN -> no effect, and none after switching to STEP.
